// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared opcodes, FSM states and access sizes for mem_access
package mem_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   // Unknown opcodes with a qualifier asserted fall back to a full word.
   function automatic size_t op_size(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: return SZ_HALF;
         OP_LW, OP_SW:         return SZ_WORD;
         default:              return SZ_WORD;
      endcase
   endfunction

   function automatic logic op_signed(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH);
   endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select and sign/zero extension
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  size_t       size,
   input  logic        sign_ext,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (size)
         SZ_BYTE: result = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
         SZ_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage data memory request FSM with alignment and bus timeout
module mem_access
   import mem_pkg::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MEM_memread,
   input  logic        MEM_memwrite,
   input  logic [31:0] MEM_address_in,
   input  logic [31:0] MEM_data_in,
   input  logic [31:0] MEM_inst,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic [31:0] mem_rdata,
   output logic        mem_misalign,
   output logic        mem_buserr
);

   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

   state_t      state;
   logic [CW-1:0] wait_cnt;
   size_t       ld_size;
   logic        ld_signed;
   logic [1:0]  ld_offset;

   logic        pending;
   logic [5:0]  opcode;
   size_t       req_size;
   logic        misaligned;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [31:0] aligned;
   logic        unused_inst;

   assign unused_inst = ^MEM_inst[25:0];
   assign pending     = MEM_memread | MEM_memwrite;
   assign opcode      = MEM_inst[31:26];
   assign mem_stall   = pending && (state != ST_DONE);

   always_comb begin
      req_size   = op_size(opcode);
      misaligned = 1'b0;
      req_be     = 4'b1111;
      req_wdata  = MEM_data_in;
      case (req_size)
         SZ_BYTE: begin
            req_be    = 4'b0001 << MEM_address_in[1:0];
            req_wdata = {4{MEM_data_in[7:0]}};
         end
         SZ_HALF: begin
            misaligned = MEM_address_in[0];
            req_be     = 4'b0011 << MEM_address_in[1:0];
            req_wdata  = {2{MEM_data_in[15:0]}};
         end
         default: misaligned = (MEM_address_in[1:0] != 2'b00);
      endcase
   end

   load_align u_load_align (
      .rdata    (dmem_rdata),
      .offset   (ld_offset),
      .size     (ld_size),
      .sign_ext (ld_signed),
      .result   (aligned)
   );

   // gnt/rvalid win over the timeout when they arrive in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_be      <= '0;
         dmem_wdata   <= '0;
         mem_rdata    <= '0;
         mem_misalign <= 1'b0;
         mem_buserr   <= 1'b0;
         ld_size      <= SZ_WORD;
         ld_signed    <= 1'b0;
         ld_offset    <= 2'b00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  if (misaligned) begin
                     mem_misalign <= 1'b1;
                     state        <= ST_DONE;
                  end else begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= MEM_memwrite;
                     dmem_addr  <= {MEM_address_in[31:2], 2'b00};
                     dmem_be    <= req_be;
                     dmem_wdata <= req_wdata;
                     ld_size    <= req_size;
                     ld_signed  <= op_signed(opcode);
                     ld_offset  <= MEM_address_in[1:0];
                     wait_cnt   <= '0;
                     state      <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (dmem_gnt) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  wait_cnt <= wait_cnt + 1'b1;
                  state    <= dmem_we ? ST_DONE : ST_WAIT;
               end else if (wait_cnt >= LAST_CNT) begin
                  dmem_req   <= 1'b0;
                  dmem_we    <= 1'b0;
                  mem_buserr <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_WAIT: begin
               if (dmem_rvalid) begin
                  mem_rdata <= aligned;
                  state     <= ST_DONE;
               end else if (wait_cnt >= LAST_CNT) begin
                  mem_buserr <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               mem_misalign <= 1'b0;
               mem_buserr   <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access
module tb_mem_access;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MEM_memread = 1'b0;
   logic        MEM_memwrite = 1'b0;
   logic [31:0] MEM_address_in = '0;
   logic [31:0] MEM_data_in = '0;
   logic [31:0] MEM_inst = '0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        mem_stall, mem_misalign, mem_buserr;
   logic [31:0] mem_rdata;

   int vectors = 0;
   int errors = 0;
   logic [31:0] last_rdata = '0;

   mem_access #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst_n(rst_n),
      .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
      .MEM_address_in(MEM_address_in), .MEM_data_in(MEM_data_in), .MEM_inst(MEM_inst),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall), .mem_rdata(mem_rdata),
      .mem_misalign(mem_misalign), .mem_buserr(mem_buserr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // 1 = byte, 2 = half, 4 = word
   function automatic int nbytes(input logic [5:0] op);
      if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1;
      if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
      return 4;
   endfunction

   // Cycle timeline: REQ cycles until gnt, then WAIT cycles until rvalid;
   // a cycle without the awaited event at index >= MAXW-1 aborts.
   task automatic model_timing(input bit st, input int gdly, input int rdly,
                               output int stalls, output int reqs, output bit berr);
      bit granted = 0;
      bit ev;
      reqs = 0; berr = 0; stalls = 0;
      for (int t = 0; t < 1000; t++) begin
         if (!granted) begin
            reqs++;
            ev = (t == gdly);
         end else begin
            ev = ((t - gdly - 1) == rdly);
         end
         if (ev && (granted || st)) begin
            stalls = t + 2;
            return;
         end
         if (ev) granted = 1;
         else if (t >= MAXW - 1) begin
            berr = 1;
            stalls = t + 2;
            return;
         end
      end
   endtask

   task automatic run_txn(input logic [5:0] op, input bit st, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rd,
                          input int gdly, input int rdly);
      int nb, exp_stalls, exp_reqs, stalls, reqs, waits;
      bit exp_berr, mis, in_wait, fin, flag_err, sgn;
      logic [31:0] exp_addr, exp_wdata, exp_load, lane;
      logic [3:0] exp_be;
      nb = nbytes(op);
      sgn = (op == 6'h20 || op == 6'h21);
      mis = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
      exp_addr = addr & 32'hFFFF_FFFC;
      exp_be = (nb == 1) ? 4'(1 << addr[1:0]) : (nb == 2) ? 4'(3 << addr[1:0]) : 4'hF;
      exp_wdata = (nb == 1) ? data[7:0] * 32'h0101_0101 :
                  (nb == 2) ? data[15:0] * 32'h0001_0001 : data;
      lane = rd >> (8 * addr[1:0]);
      if (nb == 1)      exp_load = (sgn && lane[7])  ? (lane | 32'hFFFF_FF00) : (lane & 32'hFF);
      else if (nb == 2) exp_load = (sgn && lane[15]) ? (lane | 32'hFFFF_0000) : (lane & 32'hFFFF);
      else              exp_load = rd;
      if (mis) begin
         exp_stalls = 1; exp_reqs = 0; exp_berr = 0;
      end else begin
         model_timing(st, gdly, rdly, exp_stalls, exp_reqs, exp_berr);
      end

      stalls = 0; reqs = 0; waits = 0; in_wait = 0; fin = 0; flag_err = 0;
      @(negedge clk);
      MEM_inst = {op, 26'($urandom)};
      MEM_address_in = addr;
      MEM_data_in = data;
      MEM_memread = !st;
      MEM_memwrite = st;
      for (int c = 0; c < 64 && !fin; c++) begin
         #1;
         dmem_gnt = 1'b0;
         dmem_rvalid = 1'($urandom_range(0, 1));
         dmem_rdata = $urandom;
         if (!mem_stall) begin
            fin = 1;
            check_eq("stall_cycles", stalls, exp_stalls);
            check_eq("req_cycles", reqs, exp_reqs);
            check_eq("misalign", mem_misalign, mis);
            check_eq("buserr", mem_buserr, exp_berr);
            check_eq("req_in_done", dmem_req, 1'b0);
            check_eq("flags_early", flag_err, 1'b0);
            if (!st && !mis && !exp_berr) last_rdata = exp_load;
            check_eq("mem_rdata", mem_rdata, last_rdata);
            MEM_memread = 1'b0;
            MEM_memwrite = 1'b0;
         end else begin
            stalls++;
            if (mem_misalign || mem_buserr) flag_err = 1;
            if (dmem_req) begin
               check_eq("dmem_addr", dmem_addr, exp_addr);
               check_eq("dmem_be", dmem_be, exp_be);
               check_eq("dmem_we", dmem_we, st);
               if (st) check_eq("dmem_wdata", dmem_wdata, exp_wdata);
               if (reqs == gdly) begin
                  dmem_gnt = 1'b1;
                  if (!st) in_wait = 1;
               end
               reqs++;
            end else begin
               dmem_gnt = 1'($urandom_range(0, 1));
               if (in_wait) begin
                  dmem_rvalid = (waits == rdly);
                  if (waits == rdly) dmem_rdata = rd;
                  waits++;
               end
            end
         end
         @(negedge clk);
      end
      if (!fin) check_eq("txn_timeout", 32'd0, 32'd1);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_req"}, dmem_req, 1'b0);
      check_eq({pfx, "_we"}, dmem_we, 1'b0);
      check_eq({pfx, "_be"}, dmem_be, 4'h0);
      check_eq({pfx, "_addr"}, dmem_addr, 32'h0);
      check_eq({pfx, "_wdata"}, dmem_wdata, 32'h0);
      check_eq({pfx, "_rdata"}, mem_rdata, 32'h0);
      check_eq({pfx, "_misalign"}, mem_misalign, 1'b0);
      check_eq({pfx, "_buserr"}, mem_buserr, 1'b0);
   endtask

   logic [5:0] ld_ops [7] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h3F};
   logic [5:0] st_ops [5] = '{6'h28, 6'h29, 6'h2B, 6'h00, 6'h3F};

   initial begin
      repeat (2) @(negedge clk);
      #1 check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      run_txn(6'h23, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
      run_txn(6'h20, 0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
      run_txn(6'h24, 0, 32'h103, 32'h0, 32'h80FF_0000, 1, 0);
      run_txn(6'h29, 1, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0);
      run_txn(6'h23, 0, 32'h101, 32'h0, 32'h5555_AAAA, 0, 0);
      run_txn(6'h2B, 1, 32'h300, 32'hCAFE_F00D, 32'h0, 1000, 0);
      run_txn(6'h21, 0, 32'h402, 32'h0, 32'h8001_7FFF, 3, 0);
      run_txn(6'h23, 0, 32'h500, 32'h0, 32'h1111_2222, 1, 5);

      // Reset asserted while WAIT holds an outstanding read.
      @(negedge clk);
      MEM_inst = {6'h23, 26'h0}; MEM_address_in = 32'h100; MEM_memread = 1'b1;
      @(negedge clk); #1;
      check_eq("rstw_req", dmem_req, 1'b1);
      dmem_gnt = 1'b1;
      @(negedge clk); #1;
      dmem_gnt = 1'b0; rst_n = 1'b0; MEM_memread = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
      @(negedge clk); #1;
      dmem_rvalid = 1'b0;
      check_reset_outputs("rstw");
      check_eq("rstw_stall", mem_stall, 1'b0);
      last_rdata = 32'h0;
      run_txn(6'h23, 0, 32'h600, 32'h0, 32'h0BAD_CAFE, 0, 0);

      for (int i = 0; i < 80; i++) begin
         bit st;
         logic [5:0] op;
         st = 1'($urandom_range(0, 2) == 0);
         op = st ? st_ops[$urandom_range(0, 4)] : ld_ops[$urandom_range(0, 6)];
         run_txn(op, st, $urandom, $urandom, $urandom,
                 $urandom_range(0, 4), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MAX_WAIT, default 255, SHALL set the cycles allowed in REQ/WAIT before bus-error abort.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 MEM_memread / MEM_memwrite  in  1 each  load/store qualifiers from EX_MEM.
REQ-005 MEM_address_in  in  32  effective byte address; MEM_data_in  in  32  store data; MEM_inst  in  32  instruction (opcode = bits 31:26).
REQ-006 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (word-aligned); dmem_be  out  4; dmem_wdata  out  32.
REQ-007 dmem_gnt  in  1  request accepted; dmem_rvalid  in  1  read data valid; dmem_rdata  in  32.
REQ-008 mem_stall  out  1  hold IF..EX_MEM; mem_rdata  out  32  aligned/extended load result; mem_misalign  out  1; mem_buserr  out  1.

Function
REQ-009 Access SHALL be pending when MEM_memread or MEM_memwrite is 1; opcodes: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B; other opcodes with an asserted qualifier SHALL be treated as word.
REQ-010 FSM states IDLE, REQ, WAIT, DONE; encoding from shared package.
REQ-011 IDLE: pending and aligned -> REQ; pending and misaligned (half addr[0]=1, word addr[1:0]!=0) -> DONE with mem_misalign=1, no dmem_req; else stay.
REQ-012 REQ: dmem_req=1 (registered); on dmem_gnt: store -> DONE, load -> WAIT.
REQ-013 WAIT: dmem_req=0; on dmem_rvalid, capture the aligned/extended result into mem_rdata -> DONE.
REQ-014 DONE: mem_stall=0 for exactly one cycle -> IDLE; mem_misalign/mem_buserr SHALL be valid only in DONE, 0 otherwise.
REQ-015 mem_stall SHALL be combinational: 1 when pending and state != DONE, else 0.
REQ-016 Min latency: load 3 stall cycles (IDLE, REQ with gnt, WAIT with rvalid), result in DONE; store 2 stall cycles.
REQ-017 Wait counter SHALL clear on entering REQ, increment each REQ/WAIT cycle; at MAX_WAIT -> DONE with mem_buserr=1, dmem_req dropped, mem_rdata unchanged.
REQ-018 Little-endian lanes: dmem_be = 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word); dmem_addr = {addr[31:2],2'b00}.
REQ-019 dmem_wdata: byte replicated x4, half replicated x2, word unchanged; dmem_we=1 only for stores in REQ.
REQ-020 Loads: selected lane right-justified; lb/lh sign-extend, lbu/lhu zero-extend.
REQ-021 dmem_gnt and dmem_rvalid SHALL be ignored outside REQ and WAIT respectively; gnt and rvalid in the same REQ cycle SHALL NOT skip WAIT.
REQ-022 Request outputs SHALL be sampled from inputs on REQ entry and held constant through REQ.

Reset
REQ-023 rst_n=0 SHALL force IDLE, counter 0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, mem_rdata=0, mem_misalign=0, mem_buserr=0, including mid-transaction (outstanding read data discarded).

Structure
REQ-024 Package mem_pkg SHALL hold opcode constants, FSM state encoding, size encoding (BYTE/HALF/WORD).
REQ-025 Combinational sub-module load_align SHALL perform lane select and extension; FSM, counter and request registers SHALL reside in mem_access.

Verification
REQ-026 lw addr 0x100, gnt in REQ, rvalid next cycle rdata 0xDEADBEEF -> stall 3 cycles, mem_rdata=0xDEADBEEF in DONE.
REQ-027 lb addr 0x103, rdata 0x80FF_0000 -> be=1000, mem_rdata=0xFFFFFF80; lbu same -> 0x00000080.
REQ-028 sh addr 0x202, data 0x1234ABCD -> addr 0x200, be=1100, wdata 0xABCDABCD, we=1, stall 2 cycles.
REQ-029 lw addr 0x101 -> no dmem_req, mem_misalign=1 in DONE, stall 1 cycle.
REQ-030 MAX_WAIT=4, gnt never asserted -> mem_buserr=1 after 4 REQ cycles, dmem_req deasserted.
REQ-031 rst_n low in WAIT, then rvalid -> state IDLE, mem_rdata=0, rvalid ignored.
